mpx_sample_scheduler: RTL and testbench

MPX_SAMPLE_SCHEDULER -- requirements
Module: mpx_sample_scheduler

---
 rtl/mpx_pkg.sv | 21 ++
 rtl/mpx_sched_fifo.sv | 63 ++++++
 rtl/mpx_sample_scheduler.sv | 150 +++++++++++++++
 tb/tb_mpx_sample_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpx_pkg.sv
// Shared types for the MPX sample scheduler: FSM state encoding and the stereo sample pair.
package mpx_pkg;

    localparam logic [1:0] MPX_ST_IDLE    = 2'd0;
    localparam logic [1:0] MPX_ST_PREFILL = 2'd1;
    localparam logic [1:0] MPX_ST_ALIGN   = 2'd2;
    localparam logic [1:0] MPX_ST_RUN     = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = MPX_ST_IDLE,
        StPrefill = MPX_ST_PREFILL,
        StAlign   = MPX_ST_ALIGN,
        StRun     = MPX_ST_RUN
    } mpx_sched_state_t;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } mpx_pair_t;

endpackage

// File: rtl/mpx_sched_fifo.sv
// Synchronous single-clock FIFO of stereo pairs with fill-level output and synchronous flush.
module mpx_sched_fifo
    import mpx_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  mpx_pair_t                  i_data,
    input  logic                       i_pop,
    output mpx_pair_t                  o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    mpx_pair_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_level;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/mpx_sample_scheduler.sv
// Paces buffered stereo pairs to the MPX datapath at a divided rate, aligned to the pilot phase.
// Optional underrun statistics are compiled in with `define MPX_SCHED_STATS_EN.
module mpx_sample_scheduler
    import mpx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_pilot_sync,
    input  logic [15:0]          i_in_l,
    input  logic [15:0]          i_in_r,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    output logic [15:0]          o_out_l,
    output logic [15:0]          o_out_r,
    output logic                 o_out_valid,
    output logic [1:0]           o_state,
    output logic                 o_underflow,
    input  logic                 i_stat_clr,
    output logic [15:0]          o_underflow_count
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] HALF_LEVEL = LW'(FIFO_DEPTH / 2);

    mpx_sched_state_t     r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_eff;
    mpx_pair_t            r_out;
    logic                 r_out_valid;

    mpx_pair_t            w_in;
    mpx_pair_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [LW-1:0]        w_level;
    logic [DIV_WIDTH-1:0] w_div_eff;
    logic                 w_strobe;
    logic                 w_pop;
    logic                 w_flush;

    assign w_in      = '{l: i_in_l, r: i_in_r};
    assign w_div_eff = (i_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_div;
    // Gate on i_enable so the cycle that drops enable never produces a pulse.
    assign w_strobe  = (r_state == StRun) && i_enable && (r_cnt == r_div_eff - DIV_WIDTH'(1));
    assign w_pop     = w_strobe && !w_empty;
    assign w_flush   = !i_enable && (r_state != StIdle);

    mpx_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (i_in_valid),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_div_eff   <= DIV_WIDTH'(2);
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_strobe;
            // An empty-FIFO strobe leaves r_out alone, so the previous pair repeats.
            if (w_pop) r_out <= w_head;
            if (!i_enable) begin
                r_state <= StIdle;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state <= StPrefill;
                        r_cnt   <= '0;
                    end
                    StPrefill: begin
                        if (w_level >= HALF_LEVEL) r_state <= StAlign;
                    end
                    StAlign: begin
                        if (i_pilot_sync) begin
                            r_state   <= StRun;
                            r_cnt     <= '0;
                            r_div_eff <= w_div_eff;
                        end
                    end
                    StRun: begin
                        if (w_strobe) begin
                            r_cnt     <= '0;
                            r_div_eff <= w_div_eff;
                        end else begin
                            r_cnt <= r_cnt + DIV_WIDTH'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_in_ready  = !w_full;
    assign o_out_l     = r_out.l;
    assign o_out_r     = r_out.r;
    assign o_out_valid = r_out_valid;
    assign o_state     = r_state;

`ifdef MPX_SCHED_STATS_EN
    logic        r_underflow;
    logic [15:0] r_uf_cnt;
    logic        w_underrun;

    assign w_underrun = w_strobe && w_empty;

    // A coincident clear restarts the count at 1 rather than losing the new underrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_underflow <= 1'b0;
            r_uf_cnt    <= '0;
        end else if (w_underrun) begin
            r_underflow <= 1'b1;
            if (i_stat_clr)                r_uf_cnt <= 16'd1;
            else if (r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
        end else if (i_stat_clr) begin
            r_underflow <= 1'b0;
            r_uf_cnt    <= '0;
        end
    end

    assign o_underflow       = r_underflow;
    assign o_underflow_count = r_uf_cnt;
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = i_stat_clr;
    assign o_underflow       = 1'b0;
    assign o_underflow_count = '0;
`endif

endmodule

// File: tb/tb_mpx_sample_scheduler.sv
// Self-checking bench for mpx_sample_scheduler: table-driven runs plus directed corner sequences.
module tb_mpx_sample_scheduler;

`ifdef MPX_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] div;
    logic        pilot_sync;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_valid;
    logic [1:0]  state;
    logic        underflow;
    logic        stat_clr;
    logic [15:0] underflow_count;

    mpx_sample_scheduler #(
        .FIFO_DEPTH (8),
        .DIV_WIDTH  (16)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_enable          (enable),
        .i_div             (div),
        .i_pilot_sync      (pilot_sync),
        .i_in_l            (in_l),
        .i_in_r            (in_r),
        .i_in_valid        (in_valid),
        .o_in_ready        (in_ready),
        .o_out_l           (out_l),
        .o_out_r           (out_r),
        .o_out_valid       (out_valid),
        .o_state           (state),
        .o_underflow       (underflow),
        .i_stat_clr        (stat_clr),
        .o_underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          at;
    } exp_t;

    typedef struct {
        int div;
        int np;
        int nout;
        int per;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic logic [15:0] mk_l(input int tag, input int k);
        return 16'(32'hA000 + tag * 256 + k);
    endfunction

    function automatic logic [15:0] mk_r(input int tag, input int k);
        return 16'(32'h5000 + tag * 256 + k * 3);
    endfunction

    // Scoreboard: every out_valid pulse must match the next expected pair and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_cycle", 32'(cyc), 32'(e.at));
                chk("out_l", 32'(out_l), 32'(e.l));
                chk("out_r", 32'(out_r), 32'(e.r));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        int g = 0;
        while (cyc < t && g < 1000) begin
            tick();
            g++;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int g = 0;
        while (state !== s && g < 100) begin
            tick();
            g++;
        end
        chk(name, 32'(state), 32'(s));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        div        = 16'd4;
        pilot_sync = 1'b0;
        in_l       = '0;
        in_r       = '0;
        in_valid   = 1'b0;
        stat_clr   = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_pair(input int tag, input int k);
        int g = 0;
        in_l     = mk_l(tag, k);
        in_r     = mk_r(tag, k);
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        chk("push_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pilot();
        pilot_sync = 1'b1;
        tick();
        pilot_sync = 1'b0;
    endtask

    // Expected outputs: pops in push order, then the last pushed pair repeats on underrun.
    task automatic expect_run(input int tag, input int p, input int per, input int np,
                              input int nout);
        exp_t e;
        for (int k = 0; k < nout; k++) begin
            e.l  = mk_l(tag, (k < np) ? k : np - 1);
            e.r  = mk_r(tag, (k < np) ? k : np - 1);
            e.at = p + 1 + per * (k + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_vec(input int tag, input vec_t v);
        int p;
        int last;
        do_reset();
        div    = 16'(v.div);
        enable = 1'b1;
        for (int k = 0; k < v.np; k++) push_pair(tag, k);
        wait_state(2'd2, "reach_align");
        p = cyc;
        expect_run(tag, p, v.per, v.np, v.nout);
        pilot();
        chk("run_entry", 32'(state), 32'd3);
        last = p + 1 + v.per * v.nout;
        wait_until(last);
        enable = 1'b0;
        tick();
        tick();
        chk("outputs_drained", 32'(exp_q.size()), 32'd0);
        chk("underflow", 32'(underflow), 32'((v.nout > v.np) ? STATS : 0));
        chk("underflow_count", 32'(underflow_count),
            32'((v.nout > v.np) ? STATS * (v.nout - v.np) : 0));
    endtask

    initial begin
        int p;
        int g;
        vecs[0] = '{div: 4, np: 4, nout: 6, per: 4};
        vecs[1] = '{div: 3, np: 4, nout: 7, per: 3};
        vecs[2] = '{div: 0, np: 4, nout: 5, per: 2};
        vecs[3] = '{div: 1, np: 4, nout: 5, per: 2};
        vecs[4] = '{div: 2, np: 4, nout: 4, per: 2};
        vecs[5] = '{div: 7, np: 5, nout: 5, per: 7};

        // Reset state.
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_l", 32'(out_l), 32'd0);
        chk("rst_out_r", 32'(out_r), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_underflow_count", 32'(underflow_count), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i + 1, vecs[i]);

        // Backpressure: 8 pairs fill the FIFO, the 9th waits for the first pop.
        do_reset();
        div    = 16'd2;
        enable = 1'b1;
        for (int k = 0; k < 8; k++) push_pair(10, k);
        chk("in_ready_full", 32'(in_ready), 32'd0);
        in_l     = mk_l(10, 8);
        in_r     = mk_r(10, 8);
        in_valid = 1'b1;
        wait_state(2'd2, "full_align");
        p = cyc;
        expect_run(10, p, 2, 9, 9);
        pilot();
        g = 0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        chk("push9_cycle", 32'(cyc), 32'(p + 3));
        tick();
        in_valid = 1'b0;
        wait_until(p + 19);
        enable = 1'b0;
        tick();
        tick();
        chk("full_drained", 32'(exp_q.size()), 32'd0);

        // Divider change mid-period takes effect only after the current wrap.
        do_reset();
        div    = 16'd4;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) push_pair(11, k);
        wait_state(2'd2, "divchg_align");
        p = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.l  = mk_l(11, k);
            e.r  = mk_r(11, k);
            e.at = p + 5 + 6 * k;
            exp_q.push_back(e);
        end
        pilot();
        wait_until(p + 2);
        div = 16'd6;
        wait_until(p + 23);
        enable = 1'b0;
        tick();
        tick();
        chk("divchg_drained", 32'(exp_q.size()), 32'd0);

        // Enable drop with 3 pairs buffered: IDLE next cycle, FIFO flushed, no more output.
        do_reset();
        div    = 16'd4;
        enable = 1'b1;
        for (int k = 0; k < 5; k++) push_pair(12, k);
        wait_state(2'd2, "endrop_align");
        p = cyc;
        expect_run(12, p, 4, 5, 2);
        pilot();
        wait_until(p + 10);
        enable = 1'b0;
        tick();
        chk("endrop_idle", 32'(state), 32'd0);
        chk("endrop_in_ready", 32'(in_ready), 32'd1);
        repeat (15) tick();
        enable = 1'b1;
        repeat (10) tick();
        chk("endrop_flushed_prefill", 32'(state), 32'd1);
        chk("endrop_drained", 32'(exp_q.size()), 32'd0);
        chk("endrop_no_underflow", 32'(underflow), 32'd0);
        enable = 1'b0;
        tick();

        // Statistics: clear alone, then clear coincident with an underrun strobe.
        do_reset();
        div    = 16'd2;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) push_pair(13, k);
        wait_state(2'd2, "stats_align");
        p = cyc;
        expect_run(13, p, 2, 4, 8);
        pilot();
        wait_until(p + 13);
        chk("stats_count_2", 32'(underflow_count), 32'(2 * STATS));
        chk("stats_flag_set", 32'(underflow), 32'(STATS));
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stats_cleared_count", 32'(underflow_count), 32'd0);
        chk("stats_cleared_flag", 32'(underflow), 32'd0);
        wait_until(p + 16);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stats_clr_vs_underrun_count", 32'(underflow_count), 32'(STATS));
        chk("stats_clr_vs_underrun_flag", 32'(underflow), 32'(STATS));
        enable = 1'b0;
        tick();
        tick();
        chk("stats_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-RUN aborts at once; the pending strobe never emerges.
        do_reset();
        div    = 16'd2;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) push_pair(14, k);
        wait_state(2'd2, "arst_align");
        p = cyc;
        expect_run(14, p, 2, 4, 1);
        pilot();
        wait_until(p + 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_l", 32'(out_l), 32'd0);
        chk("arst_out_r", 32'(out_r), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_underflow_count", 32'(underflow_count), 32'd0);
        chk("arst_drained", 32'(exp_q.size()), 32'd0);
        repeat (6) tick();
        chk("arst_held_state", 32'(state), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
